// File: rtl/wb_regfile_pkg.sv
// Shared opcode encodings, run-state constant and writer-set decode for the pipeline.
// ID's hazard logic imports is_writer() so both sides agree on which opcodes write r1.
package wb_regfile_pkg;

   localparam logic EXEC = 1'b1;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_HALT  = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_SLL   = 5'b00100;
   localparam logic [4:0] OP_SLA   = 5'b00101;
   localparam logic [4:0] OP_SRL   = 5'b00110;
   localparam logic [4:0] OP_SRA   = 5'b00111;
   localparam logic [4:0] OP_ADD   = 5'b01000;
   localparam logic [4:0] OP_ADDI  = 5'b01001;
   localparam logic [4:0] OP_SUB   = 5'b01010;
   localparam logic [4:0] OP_SUBI  = 5'b01011;
   localparam logic [4:0] OP_CMP   = 5'b01100;
   localparam logic [4:0] OP_AND   = 5'b01101;
   localparam logic [4:0] OP_OR    = 5'b01110;
   localparam logic [4:0] OP_XOR   = 5'b01111;
   localparam logic [4:0] OP_LDIH  = 5'b10000;
   localparam logic [4:0] OP_ADDC  = 5'b10001;
   localparam logic [4:0] OP_SUBC  = 5'b10010;
   localparam logic [4:0] OP_JUMP  = 5'b11000;
   localparam logic [4:0] OP_JMPR  = 5'b11001;
   localparam logic [4:0] OP_BZ    = 5'b11010;
   localparam logic [4:0] OP_BNZ   = 5'b11011;
   localparam logic [4:0] OP_BN    = 5'b11100;
   localparam logic [4:0] OP_BNN   = 5'b11101;
   localparam logic [4:0] OP_BC    = 5'b11110;
   localparam logic [4:0] OP_BNC   = 5'b11111;

   // Single source of truth for "this instruction writes gr[r1]".
   function automatic logic is_writer(input logic [4:0] op);
      logic w;
      w = 1'b0;
      case (op)
         OP_LOAD, OP_LDIH,
         OP_ADD, OP_ADDI, OP_ADDC,
         OP_SUB, OP_SUBI, OP_SUBC,
         OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SRL, OP_SLA, OP_SRA: w = 1'b1;
         default:                        w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/wb_regfile_regfile8x16.sv
// 8x16 register storage: one synchronous write port, eight parallel reads.
// With REG_ZERO_EN defined, entry 0 is never written and always reads zero.
module regfile8x16 (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [2:0]       waddr,
   input  logic [15:0]      wdata,
   output logic [7:0][15:0] regs
);

   logic we_eff;

`ifdef REG_ZERO_EN
   assign we_eff = we && (waddr != 3'd0);
`else
   assign we_eff = we;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         regs <= '0;
      else if (we_eff)
         regs[waddr] <= wdata;
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: WB pipeline register, register-file commit and retired counter.
// Optional hard-zero gr0 is selected with the REG_ZERO_EN macro (see regfile8x16).
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        state,
   input  logic [15:0] mem_ir,
   input  logic [15:0] reg_C,
   input  logic [15:0] d_datain,
   output logic [15:0] wb_ir,
   output logic [15:0] reg_C1,
   output logic [15:0] gr0,
   output logic [15:0] gr1,
   output logic [15:0] gr2,
   output logic [15:0] gr3,
   output logic [15:0] gr4,
   output logic [15:0] gr5,
   output logic [15:0] gr6,
   output logic [15:0] gr7,
   output logic [15:0] retired
);

   logic             run;
   logic             we;
   logic [7:0][15:0] regs;

   assign run = (state == EXEC);
   // Commit uses the pre-edge WB contents, so the write lands as the instruction leaves WB.
   assign we  = run && is_writer(wb_ir[15:11]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wb_ir   <= '0;
         reg_C1  <= '0;
         retired <= '0;
      end else if (run) begin
         wb_ir  <= mem_ir;
         reg_C1 <= (mem_ir[15:11] == OP_LOAD) ? d_datain : reg_C;
         if (wb_ir != 16'h0000)
            retired <= retired + 16'd1;
      end
   end

   regfile8x16 u_rf (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .waddr (wb_ir[10:8]),
      .wdata (reg_C1),
      .regs  (regs)
   );

   assign gr0 = regs[0];
   assign gr1 = regs[1];
   assign gr2 = regs[2];
   assign gr3 = regs[3];
   assign gr4 = regs[4];
   assign gr5 = regs[5];
   assign gr6 = regs[6];
   assign gr7 = regs[7];

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the 16-bit five-stage pipeline, and the producer side of the ID stage's operand read path. It registers the MEM-stage result into the WB pipeline register (`wb_ir`, `reg_C1`) and commits it into the eight general registers `gr0`–`gr7` one cycle later. ID reads these outputs directly or through its forwarding muxes. The block also keeps a retired-instruction counter for debug.

## Interface
- No parameters. Opcodes and the `exec` constant come from `define.v`.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low
- `state`  in  1  CPU run state; the pipeline advances only when `state == exec`
- `mem_ir`  in  16  instruction currently in MEM
- `reg_C`  in  16  ALU result carried into MEM
- `d_datain`  in  16  data-memory read data for a LOAD in MEM
- `wb_ir`  out  16  instruction in WB
- `reg_C1`  out  16  WB result value, forwarded by ID
- `gr0`…`gr7`  out  16 each  architectural registers
- `retired`  out  16  count of non-bubble instructions that completed WB

## Operation
- Instruction fields: opcode `[15:11]`, r1 (destination) `[10:8]`. A bubble is `16'h0000`.
- Writer set: LOAD, LDIH, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SLL, SRL, SLA, SRA. This must match exactly the set ID treats as hazard sources.
- On each rising edge with `state == exec`:
  - `wb_ir <= mem_ir`.
  - `reg_C1 <= d_datain` if `mem_ir` is a LOAD, otherwise `reg_C1 <= reg_C`.
  - If `wb_ir` (the current, pre-edge value) is in the writer set, `gr[wb_ir[10:8]] <= reg_C1`.
  - If `wb_ir != 16'h0000`, `retired <= retired + 1`. The counter wraps `16'hFFFF` to `16'h0000` with no flag.
- STORE, CMP, branches, JUMP, JMPR and any unknown opcode write no register. They still count as retired if nonzero.
- When `state != exec`, every register holds its value: no writes, no count.
- On reset assertion (asynchronous, at any time, including mid-stream), all outputs clear to 0 immediately: `wb_ir`, `reg_C1`, `gr0`–`gr7`, `retired`. An in-flight write is lost.
- Only one write port exists, so register writes never collide. Reading and writing the same register in one cycle is not this block's concern: ID forwards from `reg_C1` while the instruction sits in WB.

## Timing
- MEM to WB latency is 1 edge: `mem_ir`/`reg_C`/`d_datain` are visible on `wb_ir`/`reg_C1` after the next exec edge.
- WB to `gr` latency is 1 edge: the register updates on the edge that moves the instruction out of WB.
- Total latency from MEM to architectural register is 2 exec edges.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- `retired` increments on the same edge as the corresponding `gr` write.

## Configuration
- `REG_ZERO_EN` defined:
  - `gr0` is hard-wired to `16'h0000`.
  - Writes with r1 = 0 are discarded.
  - The instruction still counts as retired.
  - Forwarding a nonzero `reg_C1` for r1 = 0 is ID's concern; this block still drives `reg_C1` normally.
- `REG_ZERO_EN` undefined: `gr0` is an ordinary writable register. This is the default.

## Structure
- Opcode macros, `exec`, and a new shared macro listing the writer set go in `define.v`. ID's hazard logic is to be refactored onto that same macro.
- Sub-module `regfile8x16`:
  - 8×16 storage with one synchronous write port and eight parallel read outputs.
  - Asynchronous active-low clear.
  - `REG_ZERO_EN` handling lives here.
- The top level holds the WB pipeline register, the write-enable decode, and the retired counter.

## Test plan
- Reset mid-run: load `gr5 = 16'h1234`, drop `reset` between edges. All outputs read 0 before the next edge and stay 0 until release.
- ALU path: `mem_ir = {ADD, 3'd3, 8'h12}`, `reg_C = 16'hBEEF`.
  - After edge 1: `wb_ir` equals that instruction and `reg_C1 = 16'hBEEF`.
  - After edge 2: `gr3 = 16'hBEEF` and `retired = 1`.
- Load path: `mem_ir = {LOAD, 3'd6, 8'h05}`, `d_datain = 16'h00A5`, `reg_C = 16'h7777`. Expect `reg_C1 = 16'h00A5`, then `gr6 = 16'h00A5`.
- Non-writer and stall cases:
  - A STORE targeting r2 leaves `gr2` unchanged and still increments `retired`.
  - Holding `state != exec` for 3 cycles freezes all outputs.
- Bubble and wrap: preset `retired = 16'hFFFF`.
  - A bubble (`16'h0000`) does not increment the counter.
  - The next ADD wraps it to `16'h0000`.
- `REG_ZERO_EN`: `{ADDI, 3'd0, 8'h01}` with `reg_C = 16'h0001`.
  - Defined: `gr0` stays `16'h0000`.
  - Undefined: `gr0 = 16'h0001`.
